ninja_judge_n: RTL and testbench
================================

Name: ninja_judge_n

Overview:
- Parametrised successor of the 3-second reaction judge.
- Each round: arm a response window, accept the first new button press, compare it to the expected action, report correct / wrong / timeout exactly once.
- Keeps saturating wrong and right counters across rounds.
- Sits between the level/action sequencer (upstream) and the score/display logic (downstream). Buttons arrive already synchronised and debounced.

Parameters:
- NUM_BTN, 4, number of buttons / distinct actions (≥2).
- CNT_W, 8, width of the wrong and right counters.
- WINDOW_TICKS, 30, response window length in `tick` pulses (≥1; 30 × 100 ms = 3 s).
- TMR_W, 8, window timer width; must satisfy 2^TMR_W > WINDOW_TICKS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle time-base strobe (e.g. 100 ms)
- active  in  1  game running; low forces IDLE, counters hold
- round_start  in  1  one-cycle pulse: begin a new round
- action  in  $clog2(NUM_BTN)  expected action code, sampled at round_start
- btn  in  NUM_BTN  button levels
- clr_cnt  in  1  synchronous clear of both counters
- busy  out  1  high in ARMED
- result_valid  out  1  one-cycle pulse when a round resolves
- result_correct  out  1  qualified by result_valid
- result_timeout  out  1  qualified by result_valid
- operation  out  $clog2(NUM_BTN)  last player operation code
- wrong_cnt  out  CNT_W  wrong + timeout count, saturating
- right_cnt  out  CNT_W  correct count, saturating

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0; timer 0; stored action 0.
  - btn_q ← 0.
- Button mapping and edge detection:
  - Button i maps to operation code NUM_BTN-1-i (btn[0] = highest code).
  - btn_q registers btn every cycle. edge = btn & ~btn_q.
  - Only rising edges count. A button held across round_start is ignored until it is released and pressed again.
- FSM IDLE / ARMED / DONE:
  - IDLE/DONE → ARMED on round_start && active: latch action, clear timer.
  - ARMED, any edge:
    - Lowest-index edged button wins.
    - Register operation; result_correct = (code == stored action); result_timeout = 0.
    - Pulse result_valid next cycle (1-cycle latency); → DONE.
    - Increment right_cnt or wrong_cnt.
  - ARMED, tick with no edge:
    - timer += 1.
    - If timer == WINDOW_TICKS-1 before the increment: timeout → result_valid=1, result_timeout=1, result_correct=0, wrong_cnt += 1, operation unchanged; → DONE.
  - DONE: further presses are ignored; flags hold until the next round_start.
  - result_valid is high for exactly one cycle per resolved round.
- Boundary cases:
  - Edge and timeout-tick in the same cycle: the press wins.
  - round_start while ARMED: the round is aborted without a result or count; re-arm immediately.
  - round_start and edge in the same cycle while ARMED: round_start wins.
  - active=0 in any state: → IDLE next cycle, no result, counters hold. round_start ignored while active=0.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - clr_cnt has priority over a same-cycle increment (result 0).
  - rst_n asserted mid-round: immediate return to reset values; no result is emitted.

Optional Feature:
- Macro NINJA_JUDGE_STREAK_EN.
- With it defined, add outputs:
  - streak (CNT_W): consecutive correct rounds; +1 on correct, 0 on wrong or timeout; saturating.
  - best_streak (CNT_W): running maximum of streak, updated the same cycle.
  - clr_cnt clears both.
- Without it, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package ninja_pkg:
  - judge state enum (IDLE, ARMED, DONE).
  - function btn_to_code (index → NUM_BTN-1-index).
  - localparam ACT_W = $clog2(NUM_BTN).
- Sub-module sat_counter (parameter W; inc, clr, q), instantiated for wrong_cnt, right_cnt and the optional streak counter.
- Edge detect and priority encode stay inline.

Test Plan:
1. Defaults. round_start with action=3, then btn[0] edge 5 cycles later → result_valid one cycle after the edge, correct=1, operation=3, right_cnt=1.
2. action=0, btn[1] pressed → correct=0, operation=2, wrong_cnt=1. Hold btn[1] for 50 cycles → no further counts.
3. No press, 30 ticks → result_timeout=1 on the 30th tick, wrong_cnt=1, busy=0. Same-cycle btn edge with tick 30 → correct/wrong result instead, timeout=0.
4. btn[2] held through round_start → no result. Release, re-press → result with operation=1. btn[1] and btn[3] rising together → operation=2.
5. CNT_W=2: 5 wrong rounds → wrong_cnt=3 (saturated). clr_cnt with a simultaneous wrong result → wrong_cnt=0.
6. rst_n low mid-ARMED → all outputs 0 immediately, no result_valid. active=0 mid-round → IDLE, counters unchanged. With NINJA_JUDGE_STREAK_EN: correct, correct, wrong → streak 2→0, best_streak=2.

Source files
------------

// File: rtl/ninja_pkg.sv
// Shared types and helpers for the reaction judge.
// Pure declarations; no timing of its own.
// No flow control; consumed by ninja_judge_n and its counters.
package ninja_pkg;

    // Reference button count used for the default operation-code width.
    localparam int DEF_NUM_BTN = 4;
    localparam int ACT_W       = $clog2(DEF_NUM_BTN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } judge_state_e;

    // Button 0 carries the highest operation code, the last button carries code 0.
    function automatic int btn_to_code(input int num_btn, input int idx);
        return num_btn - 1 - idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Updates on the clock edge after inc/clr; q is registered.
// No backpressure; clr wins over a same-cycle inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Clear has priority; increment stops once the counter is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/ninja_judge_n.sv
// Reaction judge: arms a window per round, scores the first new press or a timeout.
// Result pulse one cycle after the deciding press/tick; counters update on the same edge.
// No backpressure: result_valid is a single-cycle strobe. Optional streak outputs via NINJA_JUDGE_STREAK_EN.
module ninja_judge_n
    import ninja_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int CNT_W        = 8,
    parameter int WINDOW_TICKS = 30,
    parameter int TMR_W        = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       active,
    input  logic                       round_start,
    input  logic [$clog2(NUM_BTN)-1:0] action,
    input  logic [NUM_BTN-1:0]         btn,
    input  logic                       clr_cnt,
    output logic                       busy,
    output logic                       result_valid,
    output logic                       result_correct,
    output logic                       result_timeout,
    output logic [$clog2(NUM_BTN)-1:0] operation,
    output logic [CNT_W-1:0]           wrong_cnt,
    output logic [CNT_W-1:0]           right_cnt
`ifdef NINJA_JUDGE_STREAK_EN
    ,
    output logic [CNT_W-1:0]           streak,
    output logic [CNT_W-1:0]           best_streak
`endif
);

    localparam int               OP_W     = $clog2(NUM_BTN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_TICKS - 1);

    judge_state_e       state;
    judge_state_e       state_nxt;
    logic [NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0] btn_edge;
    logic               edge_any;
    logic [OP_W-1:0]    edge_code;
    logic [OP_W-1:0]    act_q;
    logic [TMR_W-1:0]   tmr;
    logic               arm;
    logic               hit_press;
    logic               hit_tmo;
    logic               tmr_inc;
    logic               res_right;
    logic               res_wrong;

    // Remember last cycle's button levels so only rising edges count as presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign btn_edge = btn & ~btn_q;

    // Lowest-index rising button wins: scan downwards so the last hit is the lowest index.
    always_comb begin
        edge_any  = 1'b0;
        edge_code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (btn_edge[i]) begin
                edge_any  = 1'b1;
                edge_code = OP_W'(btn_to_code(NUM_BTN, i));
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes; priority is active, then round_start, then press, then tick.
    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        hit_press = 1'b0;
        hit_tmo   = 1'b0;
        tmr_inc   = 1'b0;
        if (!active) begin
            state_nxt = ST_IDLE;
        end else if (round_start) begin
            state_nxt = ST_ARMED;
            arm       = 1'b1;
        end else if (state == ST_ARMED) begin
            if (edge_any) begin
                hit_press = 1'b1;
                state_nxt = ST_DONE;
            end else if (tick) begin
                if (tmr == TMR_LAST) begin
                    hit_tmo   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
        end
    end

    assign res_right = hit_press & (edge_code == act_q);
    assign res_wrong = hit_tmo | (hit_press & (edge_code != act_q));
    assign busy      = (state == ST_ARMED);

    // Round bookkeeping and result registers; flags hold from resolution until the next arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q          <= '0;
            tmr            <= '0;
            result_valid   <= 1'b0;
            result_correct <= 1'b0;
            result_timeout <= 1'b0;
            operation      <= '0;
        end else begin
            result_valid <= hit_press | hit_tmo;
            if (arm) begin
                act_q          <= action;
                tmr            <= '0;
                result_correct <= 1'b0;
                result_timeout <= 1'b0;
            end else if (tmr_inc) begin
                tmr <= tmr + TMR_W'(1);
            end
            if (hit_press) begin
                operation      <= edge_code;
                result_correct <= res_right;
                result_timeout <= 1'b0;
            end
            if (hit_tmo) begin
                result_correct <= 1'b0;
                result_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_wrong_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_wrong),
        .clr   (clr_cnt),
        .q     (wrong_cnt)
    );

    sat_counter #(.W(CNT_W)) u_right_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_right),
        .clr   (clr_cnt),
        .q     (right_cnt)
    );

`ifdef NINJA_JUDGE_STREAK_EN
    logic [CNT_W-1:0] streak_up;

    // A wrong or timed-out round breaks the streak.
    sat_counter #(.W(CNT_W)) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_right),
        .clr   (clr_cnt | res_wrong),
        .q     (streak)
    );

    assign streak_up = (streak == {CNT_W{1'b1}}) ? streak : streak + CNT_W'(1);

    // Best streak follows the value streak takes on this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_streak <= '0;
        end else if (clr_cnt) begin
            best_streak <= '0;
        end else if (res_right && (streak_up > best_streak)) begin
            best_streak <= streak_up;
        end
    end
`endif

endmodule

// File: tb/tb_ninja_judge_n.sv
// Bench for ninja_judge_n with default parameters.
// Expected results are queued when a press/tick is driven and checked when result_valid fires.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_ninja_judge_n;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic       tick        = 1'b0;
    logic       active      = 1'b0;
    logic       round_start = 1'b0;
    logic       clr_cnt     = 1'b0;
    logic [1:0] action      = '0;
    logic [3:0] btn         = '0;
    logic       busy;
    logic       result_valid;
    logic       result_correct;
    logic       result_timeout;
    logic [1:0] operation;
    logic [7:0] wrong_cnt;
    logic [7:0] right_cnt;
`ifdef NINJA_JUDGE_STREAK_EN
    logic [7:0] streak;
    logic [7:0] best_streak;
`endif

    ninja_judge_n dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .active         (active),
        .round_start    (round_start),
        .action         (action),
        .btn            (btn),
        .clr_cnt        (clr_cnt),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_correct (result_correct),
        .result_timeout (result_timeout),
        .operation      (operation),
        .wrong_cnt      (wrong_cnt),
        .right_cnt      (right_cnt)
`ifdef NINJA_JUDGE_STREAK_EN
        ,
        .streak         (streak),
        .best_streak    (best_streak)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit corr;
        bit tmo;
        int op;
        int w;
        int r;
    } res_t;

    typedef struct {
        logic [1:0] act;
        logic [3:0] mask;
        bit         corr;
        int         op;
    } vec_t;

    res_t sb[$];
    res_t mon_e;
    vec_t vt[8];
    int   m_w  = 0;
    int   m_r  = 0;
    int   m_op = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Reference model of the counters and last operation, queued per expected result.
    task automatic expect_res(input bit corr, input bit tmo, input int op, input bit clr);
        res_t e;
        if (clr) begin
            m_w = 0;
            m_r = 0;
        end else if (corr) begin
            if (m_r < 255) m_r++;
        end else begin
            if (m_w < 255) m_w++;
        end
        if (!tmo) m_op = op;
        e.corr = corr;
        e.tmo  = tmo;
        e.op   = m_op;
        e.w    = m_w;
        e.r    = m_r;
        sb.push_back(e);
    endtask

    // Every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result_valid=1 op=%0d expected no result", operation);
            end else begin
                mon_e = sb.pop_front();
                chk("res_correct", result_correct, mon_e.corr);
                chk("res_timeout", result_timeout, mon_e.tmo);
                chk("res_operation", operation, mon_e.op);
                chk("res_wrong_cnt", wrong_cnt, mon_e.w);
                chk("res_right_cnt", right_cnt, mon_e.r);
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        step();
    endtask

    task automatic start_round(input logic [1:0] act);
        action      = act;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic play(input logic [1:0] act, input logic [3:0] mask, input bit corr, input int op);
        start_round(act);
        steps(2);
        btn = mask;
        expect_res(corr, 1'b0, op, 1'b0);
        step();
        drain("play");
        btn = '0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{act: 2'd3, mask: 4'b0001, corr: 1'b1, op: 3};
        vt[1] = '{act: 2'd0, mask: 4'b0010, corr: 1'b0, op: 2};
        vt[2] = '{act: 2'd1, mask: 4'b1010, corr: 1'b0, op: 2};
        vt[3] = '{act: 2'd2, mask: 4'b1010, corr: 1'b1, op: 2};
        vt[4] = '{act: 2'd0, mask: 4'b1000, corr: 1'b1, op: 0};
        vt[5] = '{act: 2'd1, mask: 4'b0100, corr: 1'b1, op: 1};
        vt[6] = '{act: 2'd3, mask: 4'b1111, corr: 1'b1, op: 3};
        vt[7] = '{act: 2'd2, mask: 4'b0101, corr: 1'b0, op: 3};

        // Reset values.
        #2 rst_n = 1'b0;
        steps(3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_correct", result_correct, 0);
        chk("rst_timeout", result_timeout, 0);
        chk("rst_operation", operation, 0);
        chk("rst_wrong", wrong_cnt, 0);
        chk("rst_right", right_cnt, 0);
        rst_n  = 1'b1;
        active = 1'b1;
        step();

        // Correct press, result exactly one cycle after the edge, single-cycle pulse.
        start_round(2'd3);
        steps(5);
        chk("t1_busy", busy, 1);
        btn = 4'b0001;
        expect_res(1'b1, 1'b0, 3, 1'b0);
        @(negedge clk);
        chk("t1_lat0", result_valid, 0);
        @(negedge clk);
        chk("t1_valid", result_valid, 1);
        chk("t1_right", right_cnt, 1);
        @(negedge clk);
        chk("t1_pulse", result_valid, 0);
        step();
        btn = '0;
        step();

        // Table of single-press rounds.
        for (int k = 0; k < 8; k++) begin
            start_round(vt[k].act);
            steps(3);
            chk($sformatf("vec%0d_busy", k), busy, 1);
            btn = vt[k].mask;
            expect_res(vt[k].corr, 1'b0, vt[k].op, 1'b0);
            step();
            drain($sformatf("vec%0d_drain", k));
            chk($sformatf("vec%0d_idle", k), busy, 0);
            btn = '0;
            step();
        end

        // Wrong press held for 50 cycles counts once.
        start_round(2'd0);
        steps(2);
        btn = 4'b0010;
        expect_res(1'b0, 1'b0, 2, 1'b0);
        steps(50);
        chk("t2_held_wrong", wrong_cnt, m_w);
        chk("t2_held_right", right_cnt, m_r);
        chk("t2_queue", sb.size(), 0);
        btn = '0;
        step();

        // Timeout on the 30th tick, operation kept from the previous round.
        start_round(2'd1);
        for (int t = 0; t < 29; t++) pulse_tick();
        chk("t3_still_armed", busy, 1);
        expect_res(1'b0, 1'b1, 0, 1'b0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        drain("t3_timeout");
        chk("t3_busy", busy, 0);
        chk("t3_tmo_hold", result_timeout, 1);

        // Press and final tick together: press wins.
        start_round(2'd2);
        for (int t = 0; t < 29; t++) pulse_tick();
        tick = 1'b1;
        btn  = 4'b0010;
        expect_res(1'b1, 1'b0, 2, 1'b0);
        step();
        tick = 1'b0;
        drain("t3_press_wins");
        chk("t3_no_tmo", result_timeout, 0);
        btn = '0;
        step();

        // Button held through round_start is ignored until re-pressed.
        btn = 4'b0100;
        steps(2);
        start_round(2'd1);
        steps(10);
        chk("t4_held_busy", busy, 1);
        chk("t4_held_queue", sb.size(), 0);
        btn = '0;
        steps(2);
        btn = 4'b0100;
        expect_res(1'b1, 1'b0, 1, 1'b0);
        step();
        drain("t4_repress");
        btn = '0;
        step();

        // Abort by round_start while armed: new action takes effect, no count.
        start_round(2'd0);
        steps(3);
        start_round(2'd2);
        chk("abort_busy", busy, 1);
        btn = 4'b0010;
        expect_res(1'b1, 1'b0, 2, 1'b0);
        step();
        drain("abort_result");
        btn = '0;
        step();

        // round_start and an edge in the same cycle: the edge is lost.
        start_round(2'd3);
        steps(2);
        action      = 2'd0;
        round_start = 1'b1;
        btn         = 4'b0001;
        step();
        round_start = 1'b0;
        steps(3);
        chk("rs_edge_busy", busy, 1);
        chk("rs_edge_queue", sb.size(), 0);
        btn = 4'b1001;
        expect_res(1'b1, 1'b0, 0, 1'b0);
        step();
        drain("rs_edge_result");
        btn = '0;
        step();

        // active low mid-round: back to idle, presses and round_start ignored.
        start_round(2'd1);
        steps(2);
        active = 1'b0;
        step();
        chk("inact_busy", busy, 0);
        btn = 4'b1000;
        steps(3);
        btn         = '0;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        steps(2);
        chk("inact_busy2", busy, 0);
        chk("inact_wrong", wrong_cnt, m_w);
        chk("inact_right", right_cnt, m_r);
        active = 1'b1;
        step();

        // Counter clear on its own.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        m_w     = 0;
        m_r     = 0;
        chk("clr_wrong", wrong_cnt, 0);
        chk("clr_right", right_cnt, 0);

`ifdef NINJA_JUDGE_STREAK_EN
        play(2'd3, 4'b0001, 1'b1, 3);
        chk("streak1", streak, 1);
        play(2'd3, 4'b0001, 1'b1, 3);
        chk("streak2", streak, 2);
        chk("best2a", best_streak, 2);
        play(2'd0, 4'b0001, 1'b0, 3);
        chk("streak0", streak, 0);
        chk("best2b", best_streak, 2);
`endif

        // clr_cnt beats a same-cycle wrong result.
        start_round(2'd0);
        steps(2);
        btn     = 4'b0100;
        clr_cnt = 1'b1;
        expect_res(1'b0, 1'b0, 1, 1'b1);
        step();
        clr_cnt = 1'b0;
        drain("clr_vs_inc");
        chk("clr_vs_inc_wrong", wrong_cnt, 0);
        btn = '0;
        step();

        // Saturation of the wrong counter.
        for (int k = 0; k < 260; k++) play(2'd0, 4'b0001, 1'b0, 3);
        chk("sat_wrong", wrong_cnt, 255);

        // Asynchronous reset mid-round.
        start_round(2'd2);
        steps(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", result_valid, 0);
        chk("arst_operation", operation, 0);
        chk("arst_wrong", wrong_cnt, 0);
        chk("arst_right", right_cnt, 0);
        m_w  = 0;
        m_r  = 0;
        m_op = 0;
        step();
        rst_n = 1'b1;
        btn   = 4'b0010;
        steps(3);
        chk("arst_no_result", result_valid, 0);
        chk("arst_idle", busy, 0);
        btn = '0;
        step();

        chk("final_queue", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
